// File: rtl/ayar_kontrol_if.sv
// Front-panel button / field-control bundle for the clock setting controller.
//   btn_mod, btn_arttir, btn_azalt : raw debounced buttons (asynchronous)
//   duzenleme                      : edit active, stops the time chain
//   alan                           : one-hot selected field {yil,ay,gun,saat,dakika}
//   arttir / azalt                 : one-cycle inc/dec pulses, same bit order as alan
//   yanip_sonme                    : blink enable for the selected field
// master = panel/bench side, slave = controller side.
interface ayar_kontrol_if;
   logic       btn_mod;
   logic       btn_arttir;
   logic       btn_azalt;
   logic       duzenleme;
   logic [4:0] alan;
   logic [4:0] arttir;
   logic [4:0] azalt;
   logic       yanip_sonme;

   modport master (
      output btn_mod, btn_arttir, btn_azalt,
      input  duzenleme, alan, arttir, azalt, yanip_sonme
   );

   modport slave (
      input  btn_mod, btn_arttir, btn_azalt,
      output duzenleme, alan, arttir, azalt, yanip_sonme
   );
endinterface

// File: rtl/ayar_kontrol.sv
// Setting-mode controller for the digital clock. Mode button walks
// RUN -> yil -> ay -> gun -> saat -> dakika -> RUN; up/down buttons give
// single-cycle inc/dec pulses to the selected field with hold auto-repeat.
// Idle timeout returns to RUN; blink enable toggles while editing.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : ayar_kontrol_if.slave (buttons in, field control out)
// All outputs are registered.
module ayar_kontrol #(
   parameter int unsigned HOLD_CYCLES    = 50_000_000,
   parameter int unsigned REPEAT_CYCLES  = 10_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
   parameter int unsigned BLINK_HALF     = 25_000_000
)(
   input  logic          clk,
   input  logic          reset,
   ayar_kontrol_if.slave bus
);

   // Counters count from 0 after an event, so the event fires when the
   // count shows limit-1: that lands it exactly "limit" cycles later.
   localparam logic [31:0] HOLD_LIM    = 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] REPEAT_LIM  = 32'(REPEAT_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] BLINK_LIM   = 32'(BLINK_HALF - 1);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      S_YIL    = 3'd1,
      S_AY     = 3'd2,
      S_GUN    = 3'd3,
      S_SAAT   = 3'd4,
      S_DAKIKA = 3'd5
   } state_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [4:0] field_of(input state_t s);
      case (s)
         S_YIL:    return 5'b10000;
         S_AY:     return 5'b01000;
         S_GUN:    return 5'b00100;
         S_SAAT:   return 5'b00010;
         S_DAKIKA: return 5'b00001;
         default:  return 5'b00000;
      endcase
   endfunction

   // Button conditioning: bit2 mode, bit1 up, bit0 down.
   logic [2:0] sync1, sync2, sync3;
   logic [2:0] btn_edge, held;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= {bus.btn_mod, bus.btn_arttir, bus.btn_azalt};
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign held     = sync2;
   assign btn_edge = sync2 & ~sync3;

   state_t      state, state_nx;
   logic        rep_act, rep_act_nx;   // a held button may auto-repeat
   logic        rep_up, rep_up_nx;     // direction of the repeating button
   logic        rep_rpt, rep_rpt_nx;   // 0: waiting HOLD, 1: in REPEAT spacing
   logic [31:0] rep_cnt, rep_cnt_nx;
   logic [31:0] idle_cnt, idle_nx;
   logic [31:0] blink_cnt, blink_cnt_nx;
   logic        blink, blink_nx;
   logic        inc_nx, dec_nx;
   logic [31:0] rep_lim;
   logic [4:0]  fld;
   logic        both;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      rep_act_nx   = rep_act;
      rep_up_nx    = rep_up;
      rep_rpt_nx   = rep_rpt;
      rep_cnt_nx   = rep_cnt;
      idle_nx      = sat_inc(idle_cnt);
      blink_cnt_nx = sat_inc(blink_cnt);
      blink_nx     = blink;
      inc_nx       = 1'b0;
      dec_nx       = 1'b0;
      rep_lim      = rep_rpt ? REPEAT_LIM : HOLD_LIM;
      fld          = field_of(state);
      both         = held[1] & held[0];

      if (state == RUN) begin
         rep_act_nx = 1'b0;
         rep_cnt_nx = '0;
         idle_nx    = '0;
         if (btn_edge[2]) state_nx = S_YIL;
      end else begin
         if (|btn_edge) idle_nx = '0;

         if (btn_edge[2]) begin
            // Mode wins over a simultaneous up/down edge; the held button
            // must be re-pressed before it acts on the new field.
            case (state)
               S_YIL:   state_nx = S_AY;
               S_AY:    state_nx = S_GUN;
               S_GUN:   state_nx = S_SAAT;
               S_SAAT:  state_nx = S_DAKIKA;
               default: state_nx = RUN;
            endcase
            rep_act_nx = 1'b0;
            rep_cnt_nx = '0;
         end else if (both) begin
            // Both held: silent, and only a fresh edge re-arms pulses.
            rep_act_nx = 1'b0;
            rep_cnt_nx = '0;
         end else if (btn_edge[1]) begin
            inc_nx     = 1'b1;
            rep_act_nx = 1'b1;
            rep_up_nx  = 1'b1;
            rep_rpt_nx = 1'b0;
            rep_cnt_nx = '0;
         end else if (btn_edge[0]) begin
            dec_nx     = 1'b1;
            rep_act_nx = 1'b1;
            rep_up_nx  = 1'b0;
            rep_rpt_nx = 1'b0;
            rep_cnt_nx = '0;
         end else if (idle_cnt >= TIMEOUT_LIM) begin
            state_nx   = RUN;
            rep_act_nx = 1'b0;
            rep_cnt_nx = '0;
         end else if (rep_act && (rep_up ? held[1] : held[0])) begin
            if (rep_cnt >= rep_lim) begin
               inc_nx     = rep_up;
               dec_nx     = ~rep_up;
               rep_rpt_nx = 1'b1;
               rep_cnt_nx = '0;
            end else begin
               rep_cnt_nx = sat_inc(rep_cnt);
            end
         end else begin
            rep_act_nx = 1'b0;
            rep_cnt_nx = '0;
         end
      end

      if (state_nx != state) idle_nx = '0;

      if (state_nx == RUN) begin
         blink_nx     = 1'b0;
         blink_cnt_nx = '0;
      end else if (state_nx != state) begin
         blink_nx     = 1'b1;
         blink_cnt_nx = '0;
      end else if (blink_cnt >= BLINK_LIM) begin
         blink_nx     = ~blink;
         blink_cnt_nx = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_act         <= 1'b0;
         rep_up          <= 1'b0;
         rep_rpt         <= 1'b0;
         rep_cnt         <= '0;
         idle_cnt        <= '0;
         blink_cnt       <= '0;
         blink           <= 1'b0;
         bus.duzenleme   <= 1'b0;
         bus.alan        <= '0;
         bus.arttir      <= '0;
         bus.azalt       <= '0;
         bus.yanip_sonme <= 1'b0;
      end else begin
         rep_act         <= rep_act_nx;
         rep_up          <= rep_up_nx;
         rep_rpt         <= rep_rpt_nx;
         rep_cnt         <= rep_cnt_nx;
         idle_cnt        <= idle_nx;
         blink_cnt       <= blink_cnt_nx;
         blink           <= blink_nx;
         bus.duzenleme   <= (state_nx != RUN);
         bus.alan        <= field_of(state_nx);
         bus.arttir      <= inc_nx ? fld : 5'b0;
         bus.azalt       <= dec_nx ? fld : 5'b0;
         bus.yanip_sonme <= blink_nx;
      end
   end

endmodule

// File: tb/tb_ayar_kontrol.sv
// Bench for ayar_kontrol with HOLD=20, REPEAT=5, TIMEOUT=100, BLINK_HALF=8.
// Expected pulses (cycle + value) are queued as buttons are driven and
// popped by a monitor whenever arttir/azalt is non-zero.
module tb_ayar_kontrol;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct {
      int         cyc;
      logic [4:0] inc;
      logic [4:0] dec;
   } exp_t;

   exp_t sb[$];

   ayar_kontrol_if bus();

   ayar_kontrol #(
      .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .TIMEOUT_CYCLES(100), .BLINK_HALF(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [4:0] inc, input logic [4:0] dec);
      exp_t e;
      e.cyc = c;
      e.inc = inc;
      e.dec = dec;
      sb.push_back(e);
   endtask

   task automatic mode_press();
      bus.btn_mod = 1'b1;
      step(3);
      bus.btn_mod = 1'b0;
      step(3);
   endtask

   // Pulse monitor.
   always @(negedge clk) begin
      if (!reset && ((bus.arttir | bus.azalt) != 5'b0)) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {22'b0, bus.arttir, bus.azalt}, 32'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_val", {22'b0, bus.arttir, bus.azalt}, {22'b0, e.inc, e.dec});
            chk("pulse_cyc", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [4:0] alan_seq [6];
      int e0;
      alan_seq = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00000};
      bus.btn_mod    = 1'b0;
      bus.btn_arttir = 1'b0;
      bus.btn_azalt  = 1'b0;

      // Reset state
      step(3);
      chk("rst_alan", {27'b0, bus.alan}, 32'b0);
      chk("rst_duz", {31'b0, bus.duzenleme}, 32'b0);
      chk("rst_puls", {22'b0, bus.arttir, bus.azalt}, 32'b0);
      chk("rst_blink", {31'b0, bus.yanip_sonme}, 32'b0);
      reset = 1'b0;
      step(3);

      // Full mode cycle
      for (int i = 0; i < 6; i++) begin
         mode_press();
         chk("mode_alan", {27'b0, bus.alan}, {27'b0, alan_seq[i]});
         chk("mode_duz", {31'b0, bus.duzenleme}, (i < 5) ? 32'd1 : 32'd0);
      end

      // Single up tap in S_YIL
      mode_press();
      push(cyc + 3, 5'b10000, 5'b00000);
      bus.btn_arttir = 1'b1;
      step(3);
      bus.btn_arttir = 1'b0;
      step(10);

      // Down held 40 cycles in S_GUN
      mode_press();
      mode_press();
      chk("gun_alan", {27'b0, bus.alan}, 32'b00100);
      e0 = cyc + 3;
      push(e0,      5'b0, 5'b00100);
      push(e0 + 20, 5'b0, 5'b00100);
      push(e0 + 25, 5'b0, 5'b00100);
      push(e0 + 30, 5'b0, 5'b00100);
      push(e0 + 35, 5'b0, 5'b00100);
      bus.btn_azalt = 1'b1;
      step(40);
      bus.btn_azalt = 1'b0;
      step(30);

      // Up and down together in S_SAAT
      mode_press();
      chk("saat_alan", {27'b0, bus.alan}, 32'b00010);
      bus.btn_arttir = 1'b1;
      bus.btn_azalt  = 1'b1;
      step(8);
      bus.btn_azalt  = 1'b0;
      step(5);
      bus.btn_azalt  = 1'b1;
      step(5);
      bus.btn_arttir = 1'b0;
      step(5);
      bus.btn_azalt  = 1'b0;
      step(5);
      push(cyc + 3, 5'b0, 5'b00010);
      bus.btn_azalt = 1'b1;
      step(3);
      bus.btn_azalt = 1'b0;
      step(8);

      // Reset mid-repeat in S_DAKIKA
      mode_press();
      chk("dak_alan", {27'b0, bus.alan}, 32'b00001);
      e0 = cyc + 3;
      push(e0,      5'b00001, 5'b0);
      push(e0 + 20, 5'b00001, 5'b0);
      bus.btn_arttir = 1'b1;
      step(25);
      #1 reset = 1'b1;
      #1;
      chk("arst_alan", {27'b0, bus.alan}, 32'b0);
      chk("arst_duz", {31'b0, bus.duzenleme}, 32'b0);
      chk("arst_puls", {22'b0, bus.arttir, bus.azalt}, 32'b0);
      chk("arst_blink", {31'b0, bus.yanip_sonme}, 32'b0);
      step(3);
      reset = 1'b0;
      step(30);
      chk("post_rst_alan", {27'b0, bus.alan}, 32'b0);
      mode_press();
      step(30);
      chk("held_yil_alan", {27'b0, bus.alan}, 32'b10000);
      bus.btn_arttir = 1'b0;
      step(3);
      push(cyc + 3, 5'b10000, 5'b0);
      bus.btn_arttir = 1'b1;
      step(3);
      bus.btn_arttir = 1'b0;
      step(5);

      // Timeout and blink in S_AY
      bus.btn_mod = 1'b1;
      e0 = cyc + 3;
      step(3);
      bus.btn_mod = 1'b0;
      for (int i = 0; i < 100; i++) begin
         chk("blink", {31'b0, bus.yanip_sonme}, (((i / 8) % 2) == 0) ? 32'd1 : 32'd0);
         if (i == 0 || i == 99) chk("ay_alan", {27'b0, bus.alan}, 32'b01000);
         step(1);
      end
      chk("to_cyc", cyc, e0 + 100);
      chk("to_alan", {27'b0, bus.alan}, 32'b0);
      chk("to_duz", {31'b0, bus.duzenleme}, 32'b0);
      chk("to_blink", {31'b0, bus.yanip_sonme}, 32'b0);

      step(5);
      chk("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ayar_kontrol.md
# ayar_kontrol

Setting-mode controller for the digital clock. It takes the three front-panel buttons (mode, up, down) and steps through the editable fields: year, month, day, hour, minute. For the selected field only, it issues single-cycle increment/decrement pulses to the field counters (`yil`, month, day, hour, minute). While editing it asserts a freeze so the running time chain stops, and drives a blink enable for the display of the selected field.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles a held up/down button must stay held after its first pulse before auto-repeat begins.
- `REPEAT_CYCLES`, default 10_000_000: cycles between auto-repeat pulses.
- `TIMEOUT_CYCLES`, default 1_000_000_000: idle cycles in an edit state before the block returns to RUN.
- `BLINK_HALF`, default 25_000_000: half-period of `yanip_sonme`.
- `clk`  in  1  system clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `btn_mod`  in  1  raw mode button, asynchronous, already debounced.
- `btn_arttir`  in  1  raw up button, asynchronous, already debounced.
- `btn_azalt`  in  1  raw down button, asynchronous, already debounced.
- `duzenleme`  out  1  edit active; feeds the `stop` input of the time counters.
- `alan`  out  5  one-hot selected field: bit4 year, bit3 month, bit2 day, bit1 hour, bit0 minute. All zero in RUN.
- `arttir`  out  5  one-cycle increment pulses, one bit per field, same bit order as `alan`.
- `azalt`  out  5  one-cycle decrement pulses, same bit order as `alan`.
- `yanip_sonme`  out  1  blink enable for the selected field.

## Operation
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector.
  - Level ("held") = second synchronizer stage.
- States and transitions:
  - States: RUN, S_YIL, S_AY, S_GUN, S_SAAT, S_DAKIKA.
  - A mode edge advances RUN→S_YIL→S_AY→S_GUN→S_SAAT→S_DAKIKA→RUN.
- Outputs per state:
  - `duzenleme` = 1 in every state except RUN.
  - `alan` is the one-hot code for the current state, 0 in RUN.
- Up/down in RUN: ignored. No pulses, no state change.
- Up/down in an edit state:
  - An up edge gives exactly one `arttir` pulse on the bit of the current field.
  - A down edge does the same on `azalt`.
  - Never more than one bit of `arttir|azalt` is high in a cycle.
- Auto-repeat:
  - If the button is still held, a second pulse follows HOLD_CYCLES cycles after the first.
  - Further pulses follow every REPEAT_CYCLES while the button is held.
  - Releasing the button clears the repeat counter.
- Simultaneous up and down held: no pulses, repeat counter held at 0. Pulses resume only on a new edge after one of the buttons is released.
- Mode edge in the same cycle as an up/down edge:
  - Mode wins: state advances and no pulse is issued.
  - The repeat counter is cleared, and the held button does not repeat into the new field until it is re-pressed.
- Timeout:
  - Idle counter resets on any button edge and on every state entry.
  - When it reaches TIMEOUT_CYCLES in an edit state, the next state is RUN.
- Blink:
  - In RUN, `yanip_sonme` = 0 and the blink counter = 0.
  - On entry to any edit state, `yanip_sonme` = 1 and the counter restarts.
  - Afterwards it toggles every BLINK_HALF cycles.
- Counter widths: all counters 32-bit and saturate rather than wrap.
- Reset:
  - Reset returns the block to RUN and clears all counters and synchronizers.
  - All outputs are 0: `duzenleme`, `alan`, `arttir`, `azalt`, `yanip_sonme`.
  - Reset mid-edit or mid-repeat takes effect immediately and produces no trailing pulse.

## Timing
- All outputs are registered.
- Button latency: a button first sampled high at posedge k gives an edge pulse/state change visible after posedge k+2, lasting exactly one cycle for `arttir`/`azalt`.
- Repeat spacing is measured pulse-to-pulse:
  - First repeat at pulse0 + HOLD_CYCLES.
  - Following repeats every REPEAT_CYCLES.
- Timeout: RUN is entered exactly TIMEOUT_CYCLES cycles after the last edge or state entry.
- `duzenleme` deasserts in the same cycle `alan` goes to 0.
- The downstream field counter sees the pulse in the cycle it is high. The block does not depend on counter acknowledgement.

## Test plan
All scenarios use HOLD_CYCLES=20, REPEAT_CYCLES=5, TIMEOUT_CYCLES=100, BLINK_HALF=8.
- Reset, then 6 mode presses → `alan` steps 10000, 01000, 00100, 00010, 00001, 00000; `duzenleme` is 1 for the first five steps and 0 after the last.
- In S_YIL, tap up once (3 cycles high) → exactly one `arttir`=10000 pulse, 2 cycles after the press is sampled; `azalt`=0.
- In S_GUN, hold down for 40 cycles → `azalt`=00100 pulses at t0, t0+20, t0+25, t0+30, t0+35; none after release.
- Hold up and down together in S_SAAT → no pulses. Release down, re-press down → still none; release up, re-press down → one `azalt`=00010 pulse.
- Enter S_AY and stay idle → back in RUN after 100 cycles with all outputs 0. `yanip_sonme` is 1 on entry and toggles every 8 cycles before that.
- Assert reset while in S_DAKIKA holding up mid-repeat → outputs 0 on the asynchronous edge, and no pulse after reset is released until a fresh mode press followed by an up edge.
